// File: rtl/reg_cmd_ctrl.sv
// reg_cmd_ctrl -- byte-stream command decoder bridging a UART to a register file.
//
// Protocol (one byte per i_RxValid pulse):
//   0xAA, addr, data  -> register write (o_WrEn one cycle)
//   0xBB, addr        -> register read (o_RdEn one cycle), read data is
//                        returned on the UART TX side (o_TxValid one cycle)
//   Bad opcodes, out-of-range addresses and bytes that arrive while a read
//   is in flight raise a one-cycle o_CmdError pulse.
//
// Optional feature (compile-time macro):
//   REG_CMD_TIMEOUT_EN -- abandon a read after 16 cycles without
//                         i_RdData_Valid, pulsing o_CmdError.
//
// Ports:
//   i_CLK, i_RST              clock, synchronous active-high reset
//   i_RxData, i_RxValid       received UART byte and its strobe
//   o_WrEn, o_RdEn            register-file write / read strobes
//   o_Address, o_WrData       register-file address and write data
//   i_RdData, i_RdData_Valid  register-file read data and qualifier
//   o_TxData, o_TxValid       byte to UART TX and its request strobe
//   i_TxBusy                  UART TX cannot accept a byte
//   o_CmdError                protocol error pulse
module reg_cmd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic [DATA_WIDTH-1:0] i_RxData,
    input  logic                  i_RxValid,
    output logic                  o_WrEn,
    output logic                  o_RdEn,
    output logic [ADDR_WIDTH-1:0] o_Address,
    output logic [DATA_WIDTH-1:0] o_WrData,
    input  logic [DATA_WIDTH-1:0] i_RdData,
    input  logic                  i_RdData_Valid,
    output logic [DATA_WIDTH-1:0] o_TxData,
    output logic                  o_TxValid,
    input  logic                  i_TxBusy,
    output logic                  o_CmdError
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_ADDR = 3'd1;
    localparam logic [2:0] WR_DATA = 3'd2;
    localparam logic [2:0] RD_ADDR = 3'd3;
    localparam logic [2:0] RD_WAIT = 3'd4;
    localparam logic [2:0] TX_SEND = 3'd5;

    localparam logic [DATA_WIDTH-1:0] OP_WRITE = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OP_READ  = DATA_WIDTH'(8'hBB);

    logic [2:0]            state;
    logic [DATA_WIDTH-1:0] tx_hold;
    logic                  addr_bad;
`ifdef REG_CMD_TIMEOUT_EN
    logic [3:0]            wait_cnt;
`endif

    // An address byte is only legal if it fits the register-file address.
    always_comb begin
        addr_bad = |i_RxData[DATA_WIDTH-1:ADDR_WIDTH];
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state      <= IDLE;
            tx_hold    <= '0;
            o_WrEn     <= 1'b0;
            o_RdEn     <= 1'b0;
            o_Address  <= '0;
            o_WrData   <= '0;
            o_TxData   <= '0;
            o_TxValid  <= 1'b0;
            o_CmdError <= 1'b0;
`ifdef REG_CMD_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            // Strobes are single-cycle by default; data outputs hold.
            o_WrEn     <= 1'b0;
            o_RdEn     <= 1'b0;
            o_TxValid  <= 1'b0;
            o_CmdError <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_RxValid) begin
                        if (i_RxData == OP_WRITE)
                            state <= WR_ADDR;
                        else if (i_RxData == OP_READ)
                            state <= RD_ADDR;
                        else
                            o_CmdError <= 1'b1;
                    end
                end

                WR_ADDR, RD_ADDR: begin
                    if (i_RxValid) begin
                        if (addr_bad) begin
                            o_CmdError <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            o_Address <= i_RxData[ADDR_WIDTH-1:0];
                            if (state == WR_ADDR) begin
                                state <= WR_DATA;
                            end else begin
                                o_RdEn <= 1'b1;
                                state  <= RD_WAIT;
`ifdef REG_CMD_TIMEOUT_EN
                                wait_cnt <= '0;
`endif
                            end
                        end
                    end
                end

                WR_DATA: begin
                    if (i_RxValid) begin
                        o_WrData <= i_RxData;
                        o_WrEn   <= 1'b1;
                        state    <= IDLE;
                    end
                end

                // A stray RX byte only raises an error; it never disturbs
                // the read that is already in flight.
                RD_WAIT: begin
                    if (i_RxValid)
                        o_CmdError <= 1'b1;
                    if (i_RdData_Valid) begin
                        tx_hold <= i_RdData;
                        state   <= TX_SEND;
                    end
`ifdef REG_CMD_TIMEOUT_EN
                    else if (wait_cnt == 4'd15) begin
                        o_CmdError <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
`endif
                end

                TX_SEND: begin
                    if (i_RxValid)
                        o_CmdError <= 1'b1;
                    if (!i_TxBusy) begin
                        o_TxData  <= tx_hold;
                        o_TxValid <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// tb_reg_cmd_ctrl -- self-checking bench for reg_cmd_ctrl.
// A protocol-level model predicts every output each cycle; directed
// sequences add literal expectations, then a randomized run follows.
module tb_reg_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       wr_en, rd_en;
    logic [3:0] address;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_busy;
    logic       cmd_error;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    reg_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .i_CLK          (clk),
        .i_RST          (rst),
        .i_RxData       (rx_data),
        .i_RxValid      (rx_valid),
        .o_WrEn         (wr_en),
        .o_RdEn         (rd_en),
        .o_Address      (address),
        .o_WrData       (wr_data),
        .i_RdData       (rd_data),
        .i_RdData_Valid (rd_valid),
        .o_TxData       (tx_data),
        .o_TxValid      (tx_valid),
        .i_TxBusy       (tx_busy),
        .o_CmdError     (cmd_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {EXP_OPCODE, EXP_WR_ADDR, EXP_WR_DATA, EXP_RD_ADDR, AWAIT_RD, AWAIT_TX} phase_t;

    phase_t     phase    = EXP_OPCODE;
    logic       e_wr     = 1'b0;
    logic       e_rd     = 1'b0;
    logic       e_tx     = 1'b0;
    logic       e_err    = 1'b0;
    logic [3:0] e_addr   = '0;
    logic [7:0] e_wrdata = '0;
    logic [7:0] e_txdata = '0;
    logic [7:0] held     = '0;
    int         waited   = 0;
    bit         model_live = 1'b0;

    always @(posedge clk) begin : model
        phase_t p0;
        if (rst) begin
            phase = EXP_OPCODE;
            e_wr = 0; e_rd = 0; e_tx = 0; e_err = 0;
            e_addr = '0; e_wrdata = '0; e_txdata = '0; held = '0; waited = 0;
        end else begin
            p0 = phase;
            e_wr = 0; e_rd = 0; e_tx = 0; e_err = 0;
            if (rx_valid) begin
                if (p0 == EXP_OPCODE) begin
                    if (rx_data == 8'hAA)      phase = EXP_WR_ADDR;
                    else if (rx_data == 8'hBB) phase = EXP_RD_ADDR;
                    else                       e_err = 1;
                end else if (p0 == EXP_WR_ADDR || p0 == EXP_RD_ADDR) begin
                    if (rx_data > 8'h0F) begin
                        e_err = 1;
                        phase = EXP_OPCODE;
                    end else begin
                        e_addr = rx_data[3:0];
                        if (p0 == EXP_WR_ADDR) phase = EXP_WR_DATA;
                        else begin e_rd = 1; phase = AWAIT_RD; waited = 0; end
                    end
                end else if (p0 == EXP_WR_DATA) begin
                    e_wrdata = rx_data;
                    e_wr = 1;
                    phase = EXP_OPCODE;
                end else begin
                    e_err = 1;
                end
            end
            if (p0 == AWAIT_RD) begin
                if (rd_valid) begin
                    held = rd_data;
                    phase = AWAIT_TX;
                end else begin
                    waited++;
`ifdef REG_CMD_TIMEOUT_EN
                    if (waited == 16) begin e_err = 1; phase = EXP_OPCODE; end
`endif
                end
            end
            if (p0 == AWAIT_TX && !tx_busy) begin
                e_txdata = held;
                e_tx = 1;
                phase = EXP_OPCODE;
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("m_WrEn",     32'(wr_en),     32'(e_wr));
            check("m_RdEn",     32'(rd_en),     32'(e_rd));
            check("m_Address",  32'(address),   32'(e_addr));
            check("m_WrData",   32'(wr_data),   32'(e_wrdata));
            check("m_TxData",   32'(tx_data),   32'(e_txdata));
            check("m_TxValid",  32'(tx_valid),  32'(e_tx));
            check("m_CmdError", 32'(cmd_error), 32'(e_err));
            check("m_WrRdExcl", 32'(wr_en & rd_en), 32'(0));
        end
    end

    // ---------------- register-file responder ----------------
    bit         resp_en     = 1'b1;
    bit         random_mode = 1'b0;
    int         resp_lat    = 1;
    logic [7:0] resp_data   = 8'h00;
    int         resp_cnt    = 0;

    initial begin
        rd_valid = 1'b0;
        rd_data  = 8'h00;
        forever begin
            @(negedge clk);
            rd_valid = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0 && resp_en) begin
                    rd_valid = 1'b1;
                    rd_data  = random_mode ? 8'($urandom) : resp_data;
                end
            end else if (e_rd) begin
                resp_cnt = random_mode ? int'($urandom_range(1, 4)) : resp_lat;
            end else if (random_mode && phase != AWAIT_RD && $urandom_range(0, 5) == 0) begin
                rd_valid = 1'b1;
                rd_data  = 8'($urandom);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int busy_cnt;
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        model_live = 1'b1;
        check("rst_WrEn",     32'(wr_en),     32'(0));
        check("rst_RdEn",     32'(rd_en),     32'(0));
        check("rst_Address",  32'(address),   32'(0));
        check("rst_TxValid",  32'(tx_valid),  32'(0));
        check("rst_CmdError", 32'(cmd_error), 32'(0));
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_strobes", 32'({wr_en, rd_en, tx_valid, cmd_error}), 32'(0));

        // write 0x3C to register 5
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        check("wr_WrEn",    32'(wr_en),    32'(1));
        check("wr_Address", 32'(address),  32'(5));
        check("wr_WrData",  32'(wr_data),  32'(8'h3C));
        check("wr_TxValid", 32'(tx_valid), 32'(0));
        @(negedge clk);
        check("wr_WrEn_single", 32'(wr_en),   32'(0));
        check("wr_WrData_hold", 32'(wr_data), 32'(8'h3C));

        // read register 3, data returned one cycle after o_RdEn
        resp_data = 8'h20; resp_lat = 1;
        send_byte(8'hBB); send_byte(8'h03);
        check("rd_RdEn",    32'(rd_en),   32'(1));
        check("rd_Address", 32'(address), 32'(3));
        @(negedge clk);
        @(negedge clk);
        check("rd_TxValid_early", 32'(tx_valid), 32'(0));
        @(negedge clk);
        check("rd_TxValid", 32'(tx_valid), 32'(1));
        check("rd_TxData",  32'(tx_data),  32'(8'h20));

        // back-to-back: write starts in the cycle right after TX
        send_byte(8'hAA); send_byte(8'h07); send_byte(8'h99);
        check("b2b_WrEn",    32'(wr_en),   32'(1));
        check("b2b_WrData",  32'(wr_data), 32'(8'h99));
        check("b2b_Address", 32'(address), 32'(7));

        // TX back-pressure: busy for 10 cycles
        tx_busy = 1'b1;
        send_byte(8'hBB); send_byte(8'h03);
        repeat (8) begin
            @(negedge clk);
            check("bp_TxValid_busy", 32'(tx_valid), 32'(0));
        end
        tx_busy = 1'b0;
        @(negedge clk);
        check("bp_TxValid", 32'(tx_valid), 32'(1));
        check("bp_TxData",  32'(tx_data),  32'(8'h20));

        // errors
        send_byte(8'h11);
        check("err_opcode", 32'(cmd_error), 32'(1));
        send_byte(8'hAA); send_byte(8'h15);
        check("err_addr",      32'(cmd_error), 32'(1));
        check("err_addr_WrEn", 32'(wr_en),     32'(0));
        @(negedge clk);
        check("err_addr_WrEn_next", 32'(wr_en), 32'(0));
        resp_en = 1'b0;
        send_byte(8'hBB); send_byte(8'h02);
        send_byte(8'h55);
        check("err_rdwait", 32'(cmd_error), 32'(1));
        pulse_reset();
        resp_en = 1'b1;

        // mid-command reset
        send_byte(8'hAA); send_byte(8'h02);
        check("mid_Address", 32'(address), 32'(2));
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_outputs", 32'({wr_en, rd_en, address, wr_data, tx_data, tx_valid, cmd_error}), 32'(0));
        rst = 1'b0;
        @(negedge clk);
        check("mid_post_strobes", 32'({wr_en, rd_en, tx_valid, cmd_error}), 32'(0));
        send_byte(8'h44);
        check("mid_opcode_err", 32'(cmd_error), 32'(1));
        check("mid_no_WrEn",    32'(wr_en),     32'(0));

`ifdef REG_CMD_TIMEOUT_EN
        resp_en = 1'b0;
        send_byte(8'hBB); send_byte(8'h01);
        repeat (15) begin
            @(negedge clk);
            check("to_no_err_yet", 32'(cmd_error), 32'(0));
        end
        @(negedge clk);
        check("to_err",     32'(cmd_error), 32'(1));
        check("to_TxValid", 32'(tx_valid),  32'(0));
        repeat (3) @(negedge clk);
        resp_en = 1'b1;
`endif

        // randomized traffic
        random_mode = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            rx_valid = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 9))
                0, 1, 2: rx_data = 8'hAA;
                3, 4, 5: rx_data = 8'hBB;
                6, 7:    rx_data = 8'($urandom_range(0, 15));
                default: rx_data = 8'($urandom);
            endcase
            if (busy_cnt == 0) begin
                tx_busy  = ($urandom_range(0, 1) == 1);
                busy_cnt = int'($urandom_range(1, 6));
            end else begin
                busy_cnt--;
            end
            rst = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        rx_valid = 1'b0; rst = 1'b0; tx_busy = 1'b0;
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_cmd_ctrl.md
REG_CMD_CTRL -- requirements
Module: reg_cmd_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning width of the register data and of the RX/TX bytes.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, meaning width of the register-file address.
REQ-003 SHALL have port i_CLK  in  1  system clock; the only clock; all logic on its rising edge.
REQ-004 SHALL have port i_RST  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port i_RxData  in  DATA_WIDTH  received UART byte.
REQ-006 SHALL have port i_RxValid  in  1  one-cycle pulse marking i_RxData valid.
REQ-007 SHALL have port o_WrEn  out  1  register-file write strobe.
REQ-008 SHALL have port o_RdEn  out  1  register-file read strobe.
REQ-009 SHALL have port o_Address  out  ADDR_WIDTH  register-file address.
REQ-010 SHALL have port o_WrData  out  DATA_WIDTH  register-file write data.
REQ-011 SHALL have port i_RdData  in  DATA_WIDTH  register-file read data.
REQ-012 SHALL have port i_RdData_Valid  in  1  read-data qualifier.
REQ-013 SHALL have port o_TxData  out  DATA_WIDTH  byte to UART TX.
REQ-014 SHALL have port o_TxValid  out  1  one-cycle TX request.
REQ-015 SHALL have port i_TxBusy  in  1  UART TX is busy and cannot accept a byte.
REQ-016 SHALL have port o_CmdError  out  1  one-cycle pulse on protocol error.

Function
REQ-017 SHALL implement the FSM states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT and TX_SEND.
REQ-018 SHALL handle IDLE + i_RxValid as follows: 0xAA -> WR_ADDR; 0xBB -> RD_ADDR; any other byte -> o_CmdError pulse next cycle and stay in IDLE.
REQ-019 SHALL handle an address byte in WR_ADDR/RD_ADDR as follows: if bits [DATA_WIDTH-1:ADDR_WIDTH] are nonzero, pulse o_CmdError, go to IDLE and perform no access; otherwise latch the low ADDR_WIDTH bits into o_Address.
REQ-020 SHALL, on a valid address in WR_ADDR, go to WR_DATA; on a data byte in WR_DATA, latch it into o_WrData, assert o_WrEn for exactly one cycle on the next cycle, and go to IDLE.
REQ-021 SHALL, on a valid address in RD_ADDR, assert o_RdEn for exactly one cycle on the next cycle and go to RD_WAIT.
REQ-022 SHALL, in RD_WAIT, capture i_RdData into the TX holding register on the first cycle with i_RdData_Valid=1 and go to TX_SEND.
REQ-023 SHALL, in TX_SEND with i_TxBusy=0, drive o_TxData from the holding register, assert o_TxValid for one cycle, and go to IDLE; while i_TxBusy=1 it SHALL hold in TX_SEND.
REQ-024 SHALL never assert o_WrEn and o_RdEn in the same cycle; each strobe SHALL be a registered output.
REQ-025 SHALL hold o_Address, o_WrData and o_TxData at their last values between accesses.
REQ-026 SHALL, on i_RxValid in RD_WAIT or TX_SEND, drop the byte, pulse o_CmdError, and leave the state unchanged.
REQ-027 SHALL ignore i_RdData_Valid in every state except RD_WAIT.
REQ-028 SHALL allow back-to-back commands: a 0xAA/0xBB byte arriving in the cycle after returning to IDLE is accepted.

Reset
REQ-029 SHALL, while i_RST=1 at a clock edge, force state IDLE and all outputs and internal registers to 0, including mid-command and during a pending TX.
REQ-030 SHALL issue no strobe or TX pulse in the first cycle after i_RST deasserts.

Configuration
REQ-031 SHALL implement a read timeout when REG_CMD_TIMEOUT_EN is defined: a 4-bit counter cleared on entering RD_WAIT; if 16 cycles elapse without i_RdData_Valid, pulse o_CmdError and go to IDLE with no TX.
REQ-032 SHALL, when REG_CMD_TIMEOUT_EN is not defined, wait in RD_WAIT indefinitely, with no counter logic present.

Verification
REQ-033 SHALL cover write: RX 0xAA,0x05,0x3C -> one-cycle o_WrEn with o_Address=5 and o_WrData=0x3C; no o_TxValid.
REQ-034 SHALL cover read: RX 0xBB,0x03 with the model returning 0x20 one cycle after o_RdEn -> o_TxValid with o_TxData=0x20.
REQ-035 SHALL cover TX back-pressure: the read above with i_TxBusy=1 for 10 cycles -> o_TxValid exactly one cycle after i_TxBusy falls.
REQ-036 SHALL cover errors: RX 0x11 -> o_CmdError pulse; RX 0xAA,0x15 -> o_CmdError with no o_WrEn; a byte during RD_WAIT -> o_CmdError.
REQ-037 SHALL cover mid-command reset: i_RST=1 after 0xAA,0x02 -> all outputs 0 and state IDLE; a following 0x44 -> o_CmdError (treated as an opcode).
REQ-038 SHALL cover the timeout (REG_CMD_TIMEOUT_EN defined): RX 0xBB,0x01 with no i_RdData_Valid -> o_CmdError after 16 cycles and no o_TxValid.
